// File: rtl/idma_r_burst_tracker.sv
// rtl/idma_r_burst_tracker.sv - read burst tracker: R first-beat / decouple metadata, beat checking, AR back-pressure
module idma_r_burst_fifo #(
  parameter int unsigned Depth         = 2,
  parameter int unsigned Width         = 9,
  parameter bit          PrintFifoInfo = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                testmode,
  input  logic                                push,
  input  logic [Width-1:0]                    wdata,
  input  logic                                pop,
  output logic [Width-1:0]                    rdata,
  output logic [((Depth > 1) ? $clog2(Depth) : 1):0] usage
);
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [IdxW-1:0]  rd_ptr;
  logic [IdxW-1:0]  wr_ptr;
  logic [IdxW:0]    count;
  logic             unused_cfg;

  assign unused_cfg = testmode ^ PrintFifoInfo;

  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] p);
    return (p == IdxW'(Depth - 1)) ? '0 : p + IdxW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + (IdxW+1)'(1);
      else if (!push && pop) count <= count - (IdxW+1)'(1);
    end
  end

  // Storage is not reset: the head is only consumed while usage is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign usage = count;
endmodule

module idma_r_burst_tracker #(
  parameter int unsigned NumAxInFlight = 2,
  parameter int unsigned LenWidth      = 8,
  parameter bit          PrintFifoInfo = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  input  logic [LenWidth-1:0] ar_len_i,
  input  logic                ar_decouple_aw_i,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  output logic                ar_stall_o,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  output logic                r_first_o,
  output logic                r_decouple_aw_o,
  output logic                err_o,
  output logic                busy_o
);
  localparam int unsigned IdxW   = (NumAxInFlight > 1) ? $clog2(NumAxInFlight) : 1;
  localparam int unsigned UsageW = IdxW + 1;

  logic [UsageW-1:0]   usage;
  logic [LenWidth:0]   head;
  logic [LenWidth-1:0] head_len;
  logic                head_dec;
  logic                head_valid;
  logic                full;
  logic [LenWidth-1:0] beat_q;
  logic                err_q;
  logic                ar_hs;
  logic                r_hs;
  logic                at_end;
  logic                push;
  logic                pop;
  logic                push_err;
  logic                r_err;

  assign ar_hs      = ar_valid_i & ar_ready_i;
  assign r_hs       = r_valid_i & r_ready_i;
  assign head_valid = (usage != '0);
  assign full       = (usage == UsageW'(NumAxInFlight));
  assign head_len   = head[LenWidth:1];
  assign head_dec   = head[0];
  assign at_end     = (beat_q == head_len);

  assign pop      = r_hs & head_valid & at_end;
  // A full tracker still takes a new burst when the head retires in the same cycle.
  assign push     = ar_hs & (~full | pop);
  assign push_err = ar_hs & full & ~pop;
  assign r_err    = r_hs & (~head_valid | (r_last_i != at_end));

  idma_r_burst_fifo #(
    .Depth        (NumAxInFlight),
    .Width        (LenWidth + 1),
    .PrintFifoInfo(PrintFifoInfo)
  ) i_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .testmode(testmode_i),
    .push    (push),
    .wdata   ({ar_len_i, ar_decouple_aw_i}),
    .pop     (pop),
    .rdata   (head),
    .usage   (usage)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= push_err | r_err;
      if (r_hs && head_valid) begin
        beat_q <= at_end ? '0 : beat_q + LenWidth'(1);
      end
    end
  end

  assign ar_stall_o      = full;
  assign r_first_o       = head_valid & (beat_q == '0);
  assign r_decouple_aw_o = head_valid & head_dec;
  assign err_o           = err_q;
  assign busy_o          = head_valid;
endmodule

// File: tb/tb_idma_r_burst_tracker.sv
// tb/tb_idma_r_burst_tracker.sv - vector table, corner sequences and queue-model random check for idma_r_burst_tracker
module tb_idma_r_burst_tracker;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       testmode = 1'b0;
  logic [7:0] ar_len = '0;
  logic       ar_dec = 1'b0;
  logic       ar_valid = 1'b0;
  logic       ar_ready = 1'b0;
  logic       ar_stall;
  logic       r_valid = 1'b0;
  logic       r_ready = 1'b0;
  logic       r_last = 1'b0;
  logic       r_first;
  logic       r_dec;
  logic       err;
  logic       busy;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  idma_r_burst_tracker #(
    .NumAxInFlight(N),
    .LenWidth     (8),
    .PrintFifoInfo(1'b0)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .testmode_i      (testmode),
    .ar_len_i        (ar_len),
    .ar_decouple_aw_i(ar_dec),
    .ar_valid_i      (ar_valid),
    .ar_ready_i      (ar_ready),
    .ar_stall_o      (ar_stall),
    .r_valid_i       (r_valid),
    .r_ready_i       (r_ready),
    .r_last_i        (r_last),
    .r_first_o       (r_first),
    .r_decouple_aw_o (r_dec),
    .err_o           (err),
    .busy_o          (busy)
  );

  // exp = {stall, first, decouple, err, busy}, observed before the cycle's clock edge
  typedef struct {
    logic       ar;
    logic [7:0] len;
    logic       dec;
    logic       r;
    logic       last;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    int len;
    bit dec;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  function automatic void add(input logic ar, input logic [7:0] len, input logic dec,
                              input logic r, input logic last, input logic [4:0] exp);
    vec_t v;
    v.ar = ar; v.len = len; v.dec = dec; v.r = r; v.last = last; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
  endtask

  task automatic drive(input logic arv, input logic arr, input logic [7:0] len, input logic dec,
                       input logic rv, input logic rr, input logic last);
    ar_valid = arv; ar_ready = arr; ar_len = len; ar_dec = dec;
    r_valid = rv; r_ready = rr; r_last = last;
  endtask

  function automatic logic [4:0] outs();
    return {ar_stall, r_first, r_dec, err, busy};
  endfunction

  initial begin
    int first_cnt;
    int err_cnt;
    int beat;
    bit err_p;
    logic [4:0] exp;

    // single burst
    add(1, 3, 0, 0, 0, 5'b00000);
    add(0, 0, 0, 1, 0, 5'b01001);
    add(0, 0, 0, 1, 0, 5'b00001);
    add(0, 0, 0, 1, 0, 5'b00001);
    add(0, 0, 0, 1, 1, 5'b00001);
    add(0, 0, 0, 0, 0, 5'b00000);
    // decouple propagation, A len1 dec1 then B len0 dec0
    add(1, 1, 1, 0, 0, 5'b00000);
    add(1, 0, 0, 1, 0, 5'b01101);
    add(0, 0, 0, 1, 1, 5'b10101);
    add(0, 0, 0, 1, 1, 5'b01001);
    add(0, 0, 0, 0, 0, 5'b00000);
    // full: push with pop accepted, push without pop dropped with err
    add(1, 0, 0, 0, 0, 5'b00000);
    add(1, 1, 1, 0, 0, 5'b01001);
    add(1, 0, 1, 1, 1, 5'b11001);
    add(0, 0, 0, 0, 0, 5'b11101);
    add(1, 2, 0, 0, 0, 5'b11101);
    add(0, 0, 0, 1, 0, 5'b11111);
    add(0, 0, 0, 1, 1, 5'b10101);
    add(0, 0, 0, 0, 0, 5'b01101);
    add(0, 0, 0, 1, 1, 5'b01101);
    add(0, 0, 0, 0, 0, 5'b00000);
    // last mismatch on beat 1 and missing last on beat 2
    add(1, 2, 0, 0, 0, 5'b00000);
    add(0, 0, 0, 1, 0, 5'b01001);
    add(0, 0, 0, 1, 1, 5'b00001);
    add(0, 0, 0, 1, 0, 5'b00011);
    add(0, 0, 0, 0, 0, 5'b00010);
    // R beat with nothing outstanding
    add(0, 0, 0, 1, 1, 5'b00000);
    add(0, 0, 0, 0, 0, 5'b00010);
    add(0, 0, 0, 0, 0, 5'b00000);

    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_outputs", 0, 32'(outs()), 32'(5'b00000));
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ar, tbl[i].ar, tbl[i].len, tbl[i].dec, tbl[i].r, tbl[i].r, tbl[i].last);
      @(negedge clk);
      check("table", i, 32'(outs()), 32'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // max-length burst
    drive(1, 1, 8'd255, 0, 0, 0, 0);
    @(posedge clk); #1;
    first_cnt = 0;
    err_cnt = 0;
    for (int b = 0; b < 256; b++) begin
      drive(0, 0, 0, 0, 1, 1, b == 255);
      @(negedge clk);
      first_cnt += int'(r_first);
      err_cnt += int'(err);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("maxlen_first_count", 0, 32'(first_cnt), 32'd1);
    check("maxlen_err_count", 0, 32'(err_cnt + int'(err)), 32'd0);
    check("maxlen_busy_after", 0, 32'(busy), 32'd0);
    @(posedge clk); #1;

    // reset during beat 100 of a second long burst
    drive(1, 1, 8'd255, 1, 0, 0, 0);
    @(posedge clk); #1;
    for (int b = 0; b <= 100; b++) begin
      drive(0, 0, 0, 0, 1, 1, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midburst_busy", 0, 32'(busy), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", 0, 32'(outs()), 32'(5'b00000));
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r_after_reset", 0, 32'(outs()), 32'(5'b00010));
    @(posedge clk); #1;

    // randomized traffic against a queue model
    mq.delete();
    beat = 0;
    err_p = 0;
    for (int c = 0; c < 3000; c++) begin
      bit arv, arr, rv, rr, last, arhs, rhs, popm, endm;
      int len;
      arv = 1'($urandom_range(0, 1));
      arr = 1'($urandom_range(0, 3) != 0);
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 3) != 0);
      len = $urandom_range(0, 3);
      endm = (mq.size() > 0) && (beat == mq[0].len);
      last = (mq.size() > 0) ? (endm ^ ($urandom_range(0, 9) == 0)) : 1'($urandom_range(0, 1));
      drive(arv, arr, 8'(len), 1'($urandom_range(0, 1)), rv, rr, last);
      exp = {mq.size() == N, (mq.size() > 0) && (beat == 0),
             (mq.size() > 0) && mq[0].dec, err_p, mq.size() > 0};
      @(negedge clk);
      check("random", c, 32'(outs()), 32'(exp));
      arhs = arv && arr;
      rhs = rv && rr;
      popm = rhs && endm;
      err_p = (arhs && mq.size() == N && !popm) || (rhs && (mq.size() == 0 || last != endm));
      if (rhs && mq.size() > 0) beat = endm ? 0 : beat + 1;
      if (arhs && (mq.size() < N || popm)) begin
        ent_t e;
        e.len = len;
        e.dec = ar_dec;
        mq.push_back(e);
      end
      if (popm) void'(mq.pop_front());
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
